sha256_msg_schedule: RTL and testbench

//  Upstream neighbour of the SHA-256 compressor. Accepts one 512-bit block as 16 x 32-bit

---
 rtl/sha256_msg_schedule_if.sv | 24 ++
 rtl/sha256_msg_schedule.sv | 119 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the block loader, the message schedule and the compressor.
// The message schedule is the slave side; the loader/compressor pair is the master side.
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [5:0]  out_idx;
  logic [31:0] out_k;
  logic        blk_done;
  logic        busy;

  modport slave (
    input  in_valid, in_w, out_ready,
    output in_ready, out_valid, out_w, out_idx, out_k, blk_done, busy
  );

  modport master (
    output in_valid, in_w, out_ready,
    input  in_ready, out_valid, out_w, out_idx, out_k, blk_done, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words, then emits round words W[0..ROUNDS-1]
// one per handshake, expanding in place inside a 16-entry circular window.
// Optional macro SHA256_KROM_EN adds a 64x32 round-constant ROM driving out_k.
module sha256_msg_schedule #(
  parameter int ROUNDS      = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_msg_schedule_if.slave  bus
);

  typedef enum logic {LOAD, EMIT} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic [31:0] win [BLOCK_WORDS];
  logic        blk_done_r;
  logic        busy_r;

  logic        in_ready;
  logic        out_valid;
  logic        in_fire;
  logic        out_fire;
  logic        last_word;
  logic [3:0]  t4;
  logic [31:0] expanded;
  logic [31:0] w_cur;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;
  assign last_word = (t == LAST_T);
  assign t4        = t[3:0];

  // W[t-15] lives at (t+1) mod 16 in the window; all index arithmetic wraps in 4 bits.
  assign expanded = sig1(win[t4 - 4'd2]) + win[t4 - 4'd7] + sig0(win[t4 - 4'd15]) + win[t4];
  assign w_cur    = (t[5:4] == 2'b00) ? win[t4] : expanded;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_w     = out_valid ? w_cur : 32'h0;
  assign bus.out_idx   = t;
  assign bus.blk_done  = blk_done_r;
  assign bus.busy      = busy_r;

`ifdef SHA256_KROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign bus.out_k = out_valid ? K_ROM[t] : 32'h0;
`else
  assign bus.out_k = 32'h0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Next state: leave LOAD on the 16th accepted word, leave EMIT on the last accepted round word.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: if (in_fire && cnt == 4'd15) state_next = EMIT;
      EMIT: if (out_fire && last_word)   state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Counters and status flags: load count, round index, done pulse and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      t          <= 6'd0;
      blk_done_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      blk_done_r <= out_fire && last_word;
      if (in_fire) cnt <= cnt + 4'd1;
      if (out_fire) t <= last_word ? 6'd0 : t + 6'd1;
      if (out_fire && last_word) busy_r <= 1'b0;
      else if (in_fire)          busy_r <= 1'b1;
    end
  end

  // Window: filled by input words, then each expanded word overwrites the slot it replaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= 32'h0;
    end else if (in_fire) begin
      win[cnt] <= bus.in_w;
    end else if (out_fire && t[5:4] != 2'b00) begin
      win[t4] <= w_cur;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule with a word scoreboard fed by a reference expansion.
module tb_sha256_msg_schedule;
  localparam int ROUNDS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_schedule_if bus();

  sha256_msg_schedule #(.ROUNDS(ROUNDS), .BLOCK_WORDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];
  logic [31:0] obs_w [64];
  logic [31:0] abc [16];
  logic [31:0] zero_blk [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Reference expansion over a full 64-word array; pushes expected words to the scoreboard.
  task automatic push_expected(input logic [31:0] m [16]);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else        w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    end
    for (int i = 0; i < ROUNDS; i++) q.push_back(w[i]);
  endtask

  task automatic load(input logic [31:0] m [16], input bit hold);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_w     = m[i];
      chk("in_ready_load", 32'(bus.in_ready), 32'd1);
      chk("out_valid_load", 32'(bus.out_valid), 32'd0);
      chk("busy_load", 32'(bus.busy), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("blk_done_load", 32'(bus.blk_done), 32'd0);
      $display("load word %0d = %h", i, m[i]);
      @(negedge clk);
    end
    push_expected(m);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp, input bit junk, input int stop_t);
    int got = 0;
    int cycles = 0;
    bit held = 1'b0;
    logic [31:0] hw, hk;
    logic [5:0] hi;
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_w     = 32'hDEADBEEF;
    end
    while (got < stop_t && cycles < 4000) begin
      if (held) begin
        chk("hold_w", bus.out_w, hw);
        chk("hold_idx", 32'(bus.out_idx), 32'(hi));
        chk("hold_k", bus.out_k, hk);
      end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
      chk("busy_emit", 32'(bus.busy), 32'd1);
      chk("blk_done_emit", 32'(bus.blk_done), 32'd0);
      chk("out_idx", 32'(bus.out_idx), 32'(got));
      chk("out_w", bus.out_w, q[0]);
`ifdef SHA256_KROM_EN
      if (got == 0)  chk("out_k_t0", bus.out_k, 32'h428A2F98);
      if (got == 63) chk("out_k_t63", bus.out_k, 32'hC67178F2);
`else
      chk("out_k_zero", bus.out_k, 32'h0);
`endif
      obs_w[got] = bus.out_w;
      held = !bus.out_ready;
      hw = bus.out_w;
      hi = bus.out_idx;
      hk = bus.out_k;
      if (bus.out_ready && bus.out_valid) begin
        $display("out t=%0d w=%h k=%h", got, bus.out_w, bus.out_k);
        void'(q.pop_front());
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 4000) chk("drain_timeout", 32'(got), 32'(stop_t));
    if (stop_t == ROUNDS) begin
      if (junk) bus.in_valid = 1'b0;
      chk("blk_done_pulse", 32'(bus.blk_done), 32'd1);
      chk("busy_end", 32'(bus.busy), 32'd0);
      chk("out_valid_end", 32'(bus.out_valid), 32'd0);
      chk("in_ready_end", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic check_abc_words();
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000F0000);
    chk("abc_w63", obs_w[63], 32'h12B1EDEB);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc[i] = 32'h0;
      zero_blk[i] = 32'h0;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    bus.in_valid  = 1'b0;
    bus.in_w      = 32'h0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid_during", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_w", bus.out_w, 32'h0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_k", bus.out_k, 32'h0);
    chk("rst_blk_done", 32'(bus.blk_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // 1: "abc" block, ready held high
    load(abc, 1'b0);
    drain(1'b0, 1'b0, ROUNDS);
    check_abc_words();
    @(negedge clk);
    chk("s1_done_once", 32'(bus.blk_done), 32'd0);

    // 2: backpressure
    load(abc, 1'b0);
    drain(1'b1, 1'b0, ROUNDS);
    check_abc_words();
    @(negedge clk);
    chk("s2_done_once", 32'(bus.blk_done), 32'd0);

    // 3: junk input held during EMIT
    load(abc, 1'b0);
    drain(1'b0, 1'b1, ROUNDS);
    check_abc_words();
    @(negedge clk);
    chk("s3_done_once", 32'(bus.blk_done), 32'd0);
    chk("s3_no_load", 32'(bus.busy), 32'd0);

    // 4: reset mid-block at t=30
    load(abc, 1'b0);
    drain(1'b0, 1'b0, 30);
    chk("s4_at_t30", 32'(bus.out_idx), 32'd30);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s4_rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("s4_rst_out_w", bus.out_w, 32'h0);
    chk("s4_rst_busy", 32'(bus.busy), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s4_no_done", 32'(bus.blk_done), 32'd0);
    chk("s4_in_ready", 32'(bus.in_ready), 32'd1);
    load(abc, 1'b0);
    drain(1'b0, 1'b0, ROUNDS);
    check_abc_words();

    // 5: back-to-back zero block then "abc", in_valid always high
    @(negedge clk);
    load(zero_blk, 1'b1);
    drain(1'b0, 1'b0, ROUNDS);
    chk("s5_zero_w63", obs_w[63], 32'h0);
    load(abc, 1'b1);
    drain(1'b0, 1'b0, ROUNDS);
    bus.in_valid = 1'b0;
    check_abc_words();
    @(negedge clk);
    chk("s5_done_once", 32'(bus.blk_done), 32'd0);
    chk("s5_idle_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
